// File: rtl/i2c_slave_frontend.sv
// -----------------------------------------------------------------------------
// i2c_slave_frontend
//
// I2C slave protocol engine feeding i2c_sequencer. SCL and SDA are synchronized
// into the Clock domain, START/STOP and SCL edges are detected, and a byte FSM
// matches the device address, collects an 11-bit register pointer, receives
// write bytes and serializes read bytes.
//
// Ports:
//   Clock        system clock (>= 16x SCL frequency)
//   reset        asynchronous active-low reset
//   scl_in       SCL pin (asynchronous)
//   sda_in       SDA pin (asynchronous)
//   sda_oe       1 = pull SDA low, 0 = release
//   rd_data      read byte for the current pointer, sampled on an SCL fall
//   i2c_RW       1 = write transaction, 0 = read transaction
//   i2c_addr_in  11-bit register pointer
//   i2c_data_in  last received write byte
//   i2c_addr_ack one-cycle strobe: pointer valid
//   i2c_data_ack one-cycle strobe: write byte valid
//   stop         one-cycle strobe on a STOP condition
// -----------------------------------------------------------------------------
module i2c_slave_frontend #(
   parameter logic [6:0] DEV_ADDR = 7'h50
) (
   input  logic        Clock,
   input  logic        reset,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   input  logic [7:0]  rd_data,
   output logic        i2c_RW,
   output logic [10:0] i2c_addr_in,
   output logic [7:0]  i2c_data_in,
   output logic        i2c_addr_ack,
   output logic        i2c_data_ack,
   output logic        stop
);

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_DEV     = 4'd1,
      ST_DEV_ACK = 4'd2,
      ST_PHI     = 4'd3,
      ST_PHI_ACK = 4'd4,
      ST_PLO     = 4'd5,
      ST_PLO_ACK = 4'd6,
      ST_WDATA   = 4'd7,
      ST_WACK    = 4'd8,
      ST_RDATA   = 4'd9,
      ST_RACK    = 4'd10,
      ST_IGNORE  = 4'd11
   } state_t;

   // Pin conditioning: two synchronizer stages plus one history stage per pin.
   logic scl_meta_q, scl_sync_q, scl_hist_q;
   logic sda_meta_q, sda_sync_q, sda_hist_q;

   logic scl_rise_s, scl_fall_s, start_det_s, stop_det_s;
   logic rx_state_s, bit_state_s;

   state_t      state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic        byte_full_q, byte_full_d;
   logic [7:0]  shift_q, shift_d;
   logic        sda_oe_q, sda_oe_d;
   logic        i2c_rw_q, i2c_rw_d;
   logic [10:0] ptr_q, ptr_d;
   logic [7:0]  data_q, data_d;
   logic        addr_ack_q, addr_ack_d;
   logic        data_ack_q, data_ack_d;
   logic        stop_q, stop_d;
   logic        ack_pend_q, ack_pend_d;

   // Synchronizer and history flops; idle-bus reset value avoids false edges.
   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         scl_meta_q <= 1'b1;
         scl_sync_q <= 1'b1;
         scl_hist_q <= 1'b1;
         sda_meta_q <= 1'b1;
         sda_sync_q <= 1'b1;
         sda_hist_q <= 1'b1;
      end else begin
         scl_meta_q <= scl_in;
         scl_sync_q <= scl_meta_q;
         scl_hist_q <= scl_sync_q;
         sda_meta_q <= sda_in;
         sda_sync_q <= sda_meta_q;
         sda_hist_q <= sda_sync_q;
      end
   end

   assign scl_rise_s  =  scl_sync_q & ~scl_hist_q;
   assign scl_fall_s  = ~scl_sync_q &  scl_hist_q;
   // SDA edges only count as START/STOP when SCL was high on both samples.
   assign start_det_s = scl_sync_q & scl_hist_q & ~sda_sync_q &  sda_hist_q;
   assign stop_det_s  = scl_sync_q & scl_hist_q &  sda_sync_q & ~sda_hist_q;

   // States that shift bits in from the bus.
   assign rx_state_s  = (state_q == ST_DEV) || (state_q == ST_PHI) ||
                        (state_q == ST_PLO) || (state_q == ST_WDATA);
   // States whose SCL rises advance the bit counter.
   assign bit_state_s = rx_state_s || (state_q == ST_RDATA);

   // FSM state register.
   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; STOP outranks START, both outrank bit events.
   always_comb begin
      state_d = state_q;
      if (stop_det_s) begin
         state_d = ST_IDLE;
      end else if (start_det_s) begin
         state_d = ST_DEV;
      end else begin
         case (state_q)
            ST_IDLE:    state_d = ST_IDLE;
            ST_DEV:     if (scl_fall_s && byte_full_q)
                           state_d = (shift_q[7:1] == DEV_ADDR) ? ST_DEV_ACK : ST_IGNORE;
                        else
                           state_d = ST_DEV;
            ST_DEV_ACK: if (scl_fall_s)
                           state_d = i2c_rw_q ? ST_PHI : ST_RDATA;
                        else
                           state_d = ST_DEV_ACK;
            ST_PHI:     state_d = (scl_fall_s && byte_full_q) ? ST_PHI_ACK : ST_PHI;
            ST_PHI_ACK: state_d = scl_fall_s ? ST_PLO : ST_PHI_ACK;
            ST_PLO:     state_d = (scl_fall_s && byte_full_q) ? ST_PLO_ACK : ST_PLO;
            ST_PLO_ACK: state_d = scl_fall_s ? ST_WDATA : ST_PLO_ACK;
            ST_WDATA:   state_d = (scl_fall_s && byte_full_q) ? ST_WACK : ST_WDATA;
            ST_WACK:    state_d = scl_fall_s ? ST_WDATA : ST_WACK;
            ST_RDATA:   state_d = (scl_fall_s && byte_full_q) ? ST_RACK : ST_RDATA;
            // A master NACK ends the read; after an ACK the next fall reloads.
            ST_RACK:    if (scl_rise_s)
                           state_d = sda_sync_q ? ST_IGNORE : ST_RACK;
                        else if (scl_fall_s)
                           state_d = ST_RDATA;
                        else
                           state_d = ST_RACK;
            ST_IGNORE:  state_d = ST_IGNORE;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   // Datapath and output next values: bit counter, shifter, pointer, strobes.
   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      byte_full_d = byte_full_q;
      shift_d     = shift_q;
      sda_oe_d    = sda_oe_q;
      i2c_rw_d    = i2c_rw_q;
      ptr_d       = ptr_q;
      data_d      = data_q;
      addr_ack_d  = 1'b0;
      data_ack_d  = 1'b0;
      stop_d      = 1'b0;
      ack_pend_d  = 1'b0;

      if (stop_det_s) begin
         sda_oe_d    = 1'b0;
         stop_d      = 1'b1;
         bit_cnt_d   = 3'd0;
         byte_full_d = 1'b0;
      end else if (start_det_s) begin
         sda_oe_d    = 1'b0;
         bit_cnt_d   = 3'd0;
         byte_full_d = 1'b0;
      end else begin
         if (scl_rise_s && bit_state_s) begin
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_full_d = (bit_cnt_q == 3'd7);
            shift_d     = rx_state_s ? {shift_q[6:0], sda_sync_q} : shift_q;
         end else begin
            bit_cnt_d   = bit_cnt_q;
         end

         case (state_q)
            ST_DEV: begin
               if (scl_fall_s && byte_full_q) begin
                  bit_cnt_d   = 3'd0;
                  byte_full_d = 1'b0;
                  if (shift_q[7:1] == DEV_ADDR) begin
                     sda_oe_d = 1'b1;
                     i2c_rw_d = ~shift_q[0];
                  end else begin
                     sda_oe_d = 1'b0;
                  end
               end else begin
                  sda_oe_d = sda_oe_q;
               end
            end
            ST_DEV_ACK: begin
               // Reads announce the pointer on the ACK rise so rd_data has
               // the rest of the SCL high time to settle before the fall.
               addr_ack_d = scl_rise_s & ~i2c_rw_q;
               if (scl_fall_s && i2c_rw_q) begin
                  sda_oe_d = 1'b0;
               end else if (scl_fall_s) begin
                  shift_d  = rd_data;
                  sda_oe_d = ~rd_data[7];
               end else begin
                  sda_oe_d = sda_oe_q;
               end
            end
            ST_PHI: begin
               if (scl_fall_s && byte_full_q) begin
                  bit_cnt_d    = 3'd0;
                  byte_full_d  = 1'b0;
                  ptr_d[10:8]  = shift_q[2:0];
                  sda_oe_d     = 1'b1;
               end else begin
                  sda_oe_d = sda_oe_q;
               end
            end
            ST_PLO: begin
               if (scl_fall_s && byte_full_q) begin
                  bit_cnt_d   = 3'd0;
                  byte_full_d = 1'b0;
                  ptr_d[7:0]  = shift_q;
                  addr_ack_d  = 1'b1;
                  i2c_rw_d    = 1'b1;
                  sda_oe_d    = 1'b1;
               end else begin
                  sda_oe_d = sda_oe_q;
               end
            end
            ST_WDATA: begin
               if (scl_fall_s && byte_full_q) begin
                  bit_cnt_d   = 3'd0;
                  byte_full_d = 1'b0;
                  data_d      = shift_q;
                  data_ack_d  = 1'b1;
                  sda_oe_d    = 1'b1;
               end else begin
                  sda_oe_d = sda_oe_q;
               end
            end
            ST_PHI_ACK, ST_PLO_ACK, ST_WACK: begin
               sda_oe_d = scl_fall_s ? 1'b0 : sda_oe_q;
            end
            ST_RDATA: begin
               // Each fall presents the next bit; after bit 0 release for RACK.
               if (scl_fall_s && byte_full_q) begin
                  bit_cnt_d   = 3'd0;
                  byte_full_d = 1'b0;
                  sda_oe_d    = 1'b0;
               end else if (scl_fall_s) begin
                  shift_d  = {shift_q[6:0], 1'b0};
                  sda_oe_d = ~shift_q[6];
               end else begin
                  sda_oe_d = sda_oe_q;
               end
            end
            ST_RACK: begin
               if (scl_rise_s) begin
                  ptr_d      = ptr_q + 11'd1;
                  ack_pend_d = ~sda_sync_q;
               end else if (scl_fall_s) begin
                  bit_cnt_d   = 3'd0;
                  byte_full_d = 1'b0;
                  shift_d     = rd_data;
                  sda_oe_d    = ~rd_data[7];
               end else begin
                  ptr_d = ptr_q;
               end
            end
            default: begin
               sda_oe_d = 1'b0;
            end
         endcase
      end

      // The post-increment pointer strobe lands one cycle after the ACK rise.
      if (ack_pend_q) begin
         addr_ack_d = 1'b1;
      end else begin
         addr_ack_d = addr_ack_d;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         bit_cnt_q   <= 3'd0;
         byte_full_q <= 1'b0;
         shift_q     <= 8'd0;
         sda_oe_q    <= 1'b0;
         i2c_rw_q    <= 1'b0;
         ptr_q       <= 11'd0;
         data_q      <= 8'd0;
         addr_ack_q  <= 1'b0;
         data_ack_q  <= 1'b0;
         stop_q      <= 1'b0;
         ack_pend_q  <= 1'b0;
      end else begin
         bit_cnt_q   <= bit_cnt_d;
         byte_full_q <= byte_full_d;
         shift_q     <= shift_d;
         sda_oe_q    <= sda_oe_d;
         i2c_rw_q    <= i2c_rw_d;
         ptr_q       <= ptr_d;
         data_q      <= data_d;
         addr_ack_q  <= addr_ack_d;
         data_ack_q  <= data_ack_d;
         stop_q      <= stop_d;
         ack_pend_q  <= ack_pend_d;
      end
   end

   assign sda_oe       = sda_oe_q;
   assign i2c_RW       = i2c_rw_q;
   assign i2c_addr_in  = ptr_q;
   assign i2c_data_in  = data_q;
   assign i2c_addr_ack = addr_ack_q;
   assign i2c_data_ack = data_ack_q;
   assign stop         = stop_q;

endmodule

// File: tb/tb_i2c_slave_frontend.sv
// -----------------------------------------------------------------------------
// tb_i2c_slave_frontend
//
// Directed bench: a bus-master model drives SCL/SDA at 16 Clock cycles per SCL
// period (wired-AND with the slave's open-drain pull-down), a negedge monitor
// logs strobes, and check_value compares against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_i2c_slave_frontend;

   logic        clock_s = 1'b0;
   logic        reset_s = 1'b0;
   logic        scl_m   = 1'b1;
   logic        sda_m   = 1'b1;
   logic        sda_in_s;
   logic        sda_oe_s;
   logic [7:0]  rd_data_s;
   logic        rw_s;
   logic [10:0] addr_s;
   logic [7:0]  data_s;
   logic        addr_ack_s, data_ack_s, stop_s;

   int checks_cnt = 0;
   int errors_cnt = 0;

   assign sda_in_s = sda_m & ~sda_oe_s;

   // Register-file stand-in: a fixed function of the pointer.
   function automatic logic [7:0] rd_fn(input logic [10:0] a);
      return a[7:0] ^ {5'd0, a[10:8]} ^ 8'hC3;
   endfunction

   assign rd_data_s = rd_fn(addr_s);

   i2c_slave_frontend #(.DEV_ADDR(7'h50)) dut (
      .Clock        (clock_s),
      .reset        (reset_s),
      .scl_in       (scl_m),
      .sda_in       (sda_in_s),
      .sda_oe       (sda_oe_s),
      .rd_data      (rd_data_s),
      .i2c_RW       (rw_s),
      .i2c_addr_in  (addr_s),
      .i2c_data_in  (data_s),
      .i2c_addr_ack (addr_ack_s),
      .i2c_data_ack (data_ack_s),
      .stop         (stop_s)
   );

   always #5 clock_s = ~clock_s;

   // Strobe monitor.
   int          cyc = 0;
   int          addr_n = 0, data_n = 0, stop_n = 0, oe_n = 0, wide_n = 0;
   int          last_strobe = -1000;
   int          min_gap = 1000;
   logic [10:0] addr_log [0:31];
   logic        rw_log   [0:31];
   logic [7:0]  data_log [0:31];
   logic        prev_a = 1'b0, prev_d = 1'b0, prev_p = 1'b0;

   always @(negedge clock_s) begin
      cyc = cyc + 1;
      if (addr_ack_s) begin
         if (addr_n < 32) begin
            addr_log[addr_n] = addr_s;
            rw_log[addr_n]   = rw_s;
         end
         addr_n = addr_n + 1;
      end
      if (data_ack_s) begin
         if (data_n < 32) data_log[data_n] = data_s;
         data_n = data_n + 1;
      end
      if (stop_s) stop_n = stop_n + 1;
      if ((addr_ack_s && prev_a) || (data_ack_s && prev_d) || (stop_s && prev_p))
         wide_n = wide_n + 1;
      if (addr_ack_s || data_ack_s || stop_s) begin
         if (cyc - last_strobe < min_gap) min_gap = cyc - last_strobe;
         last_strobe = cyc;
      end
      if (sda_oe_s) oe_n = oe_n + 1;
      prev_a = addr_ack_s;
      prev_d = data_ack_s;
      prev_p = stop_s;
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt = checks_cnt + 1;
      if (got !== exp) begin
         errors_cnt = errors_cnt + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock_s);
      #1;
   endtask

   task automatic bus_start();
      if (scl_m == 1'b0) begin
         sda_m = 1'b1; tick(4);
         scl_m = 1'b1; tick(4);
      end
      sda_m = 1'b0; tick(4);
      scl_m = 1'b0; tick(4);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; tick(4);
      scl_m = 1'b1; tick(4);
      sda_m = 1'b1; tick(8);
   endtask

   task automatic write_bit(input logic b);
      sda_m = b;    tick(4);
      scl_m = 1'b1; tick(8);
      scl_m = 1'b0; tick(4);
   endtask

   task automatic read_bit(output logic b);
      sda_m = 1'b1; tick(4);
      scl_m = 1'b1; tick(4);
      b = sda_in_s; tick(4);
      scl_m = 1'b0; tick(4);
   endtask

   // Returns the slave's ACK bit (0 = ACK).
   task automatic write_byte(input logic [7:0] v, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(v[i]);
      read_bit(ack);
   endtask

   task automatic read_byte(output logic [7:0] v, input logic nack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         v[i] = b;
      end
      write_bit(nack);
   endtask

   // Watchdog: the whole run is a few thousand cycles.
   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic       ack;
      logic [5:0] acks;
      logic [7:0] rb0, rb1;
      int         a0, d0, s0, o0;

      // Reset state with an idle bus.
      tick(5);
      check_value("rst_sda_oe",   sda_oe_s,   32'd0);
      check_value("rst_rw",       rw_s,       32'd0);
      check_value("rst_addr",     addr_s,     32'd0);
      check_value("rst_data",     data_s,     32'd0);
      check_value("rst_strobes",  {addr_ack_s, data_ack_s, stop_s}, 32'd0);
      reset_s = 1'b1;
      tick(5);

      // Write: A0 03 45 11 22.
      a0 = addr_n; d0 = data_n; s0 = stop_n;
      bus_start();
      write_byte(8'hA0, acks[0]);
      write_byte(8'h03, acks[1]);
      write_byte(8'h45, acks[2]);
      write_byte(8'h11, acks[3]);
      write_byte(8'h22, acks[4]);
      bus_stop();
      check_value("wr_acks",     acks[4:0],   32'd0);
      check_value("wr_addr_n",   addr_n - a0, 32'd1);
      check_value("wr_addr",     addr_log[a0], 32'h345);
      check_value("wr_rw",       rw_log[a0],   32'd1);
      check_value("wr_data_n",   data_n - d0,  32'd2);
      check_value("wr_data0",    data_log[d0],     32'h11);
      check_value("wr_data1",    data_log[d0 + 1], 32'h22);
      check_value("wr_stop_n",   stop_n - s0,  32'd1);

      // Random read with pointer wrap: A0 07 FF rSTART A1, ACK, NACK.
      a0 = addr_n; d0 = data_n; s0 = stop_n;
      bus_start();
      write_byte(8'hA0, acks[0]);
      write_byte(8'h07, acks[1]);
      write_byte(8'hFF, acks[2]);
      bus_start();
      write_byte(8'hA1, acks[3]);
      read_byte(rb0, 1'b0);
      read_byte(rb1, 1'b1);
      bus_stop();
      check_value("rd_acks",     acks[3:0],   32'd0);
      check_value("rd_addr_n",   addr_n - a0, 32'd3);
      check_value("rd_addr_wr",  {rw_log[a0], addr_log[a0]},         {21'd0, 1'b1, 11'h7FF});
      check_value("rd_addr_0",   {rw_log[a0 + 1], addr_log[a0 + 1]}, {21'd0, 1'b0, 11'h7FF});
      check_value("rd_addr_1",   {rw_log[a0 + 2], addr_log[a0 + 2]}, {21'd0, 1'b0, 11'h000});
      check_value("rd_byte0",    rb0, 32'h3B);
      check_value("rd_byte1",    rb1, 32'hC3);
      check_value("rd_data_n",   data_n - d0, 32'd0);
      check_value("rd_ptr_end",  addr_s, 32'h001);
      check_value("rd_stop_n",   stop_n - s0, 32'd1);

      // Wrong device address: never driven, no strobes, STOP still reported.
      a0 = addr_n; d0 = data_n; s0 = stop_n; o0 = oe_n;
      bus_start();
      write_byte(8'hB0, acks[0]);
      write_byte(8'h12, acks[1]);
      bus_stop();
      check_value("bad_nacks",   acks[1:0],   32'd3);
      check_value("bad_oe",      oe_n - o0,   32'd0);
      check_value("bad_strobes", (addr_n - a0) + (data_n - d0), 32'd0);
      check_value("bad_stop_n",  stop_n - s0, 32'd1);

      // Repeated START after a 4-bit partial data byte.
      a0 = addr_n; d0 = data_n;
      bus_start();
      write_byte(8'hA0, acks[0]);
      write_byte(8'h01, acks[1]);
      write_byte(8'h23, acks[2]);
      write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
      bus_start();
      write_byte(8'hA1, acks[3]);
      read_byte(rb0, 1'b1);
      bus_stop();
      check_value("rs_acks",     acks[3:0],   32'd0);
      check_value("rs_addr_n",   addr_n - a0, 32'd2);
      check_value("rs_addr_rd",  {rw_log[a0 + 1], addr_log[a0 + 1]}, {21'd0, 1'b0, 11'h123});
      check_value("rs_byte",     rb0, 32'hE1);
      check_value("rs_data_n",   data_n - d0, 32'd0);

      // Back-to-back write bytes at the minimum SCL period.
      a0 = addr_n; d0 = data_n;
      bus_start();
      write_byte(8'hA0, acks[0]);
      write_byte(8'h00, acks[1]);
      write_byte(8'h10, acks[2]);
      write_byte(8'hAA, acks[3]);
      write_byte(8'h55, acks[4]);
      write_byte(8'h0F, acks[5]);
      bus_stop();
      check_value("b2b_acks",    acks, 32'd0);
      check_value("b2b_addr",    addr_log[a0], 32'h010);
      check_value("b2b_data_n",  data_n - d0, 32'd3);
      check_value("b2b_data",    {data_log[d0], data_log[d0 + 1], data_log[d0 + 2]}, 32'hAA550F);
      check_value("strobe_wide", wide_n, 32'd0);
      check_value("strobe_gap",  (min_gap >= 8) ? 32'd1 : 32'd0, 32'd1);

      // Reset asserted while the slave drives an address ACK.
      bus_start();
      for (int i = 7; i >= 0; i--) write_bit(((8'hA0 >> i) & 8'h01) != 8'h00);
      tick(2);
      check_value("ack_driven",  sda_oe_s, 32'd1);
      #2;
      reset_s = 1'b0;
      #1;
      check_value("async_rst_oe", sda_oe_s, 32'd0);
      sda_m = 1'b1;
      scl_m = 1'b1;
      tick(5);
      reset_s = 1'b1;
      tick(5);
      check_value("rst2_ptr",    addr_s, 32'd0);
      check_value("rst2_data",   {rw_s, data_s}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
